// File: rtl/hermes_switch_ctrl_pkg.sv
// Shared types, port constants and the routing function for the Hermes
// switch controller.
package hermes_switch_ctrl_pkg;

   localparam int HERMES_EAST      = 0;
   localparam int HERMES_WEST      = 1;
   localparam int HERMES_NORTH     = 2;
   localparam int HERMES_SOUTH     = 3;
   localparam int HERMES_NCARDINAL = 4;

   typedef enum logic {HERMES_XY, HERMES_YX} hermes_routing_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARBIT,
      S_ROUTE,
      S_GRANT,
      S_ACK
   } hermes_state_t;

   // Fields arrive zero-extended so one function serves any coordinate width.
   function automatic logic [31:0] hermes_route(
      input logic            force_en,
      input logic [31:0]     fport,
      input logic [31:0]     tx,
      input logic [31:0]     ty,
      input logic [31:0]     x,
      input logic [31:0]     y,
      input logic [31:0]     lsel,
      input logic [31:0]     nlocal,
      input hermes_routing_t routing
   );
      logic [31:0] nport;
      logic [31:0] xdir;
      logic [31:0] ydir;
      logic [31:0] loc;
      nport = 32'(HERMES_NCARDINAL) + nlocal;
      xdir  = (tx > x) ? 32'(HERMES_EAST)  : 32'(HERMES_WEST);
      ydir  = (ty > y) ? 32'(HERMES_NORTH) : 32'(HERMES_SOUTH);
      loc   = (lsel >= nlocal) ? 32'(HERMES_NCARDINAL) : 32'(HERMES_NCARDINAL) + lsel;
      if (force_en)
         return (fport >= nport) ? 32'(HERMES_NCARDINAL) : fport;
      if (routing == HERMES_XY)
         return (tx != x) ? xdir : ((ty != y) ? ydir : loc);
      return (ty != y) ? ydir : ((tx != x) ? xdir : loc);
   endfunction

endpackage

// File: rtl/hermes_switch_ctrl_if.sv
// Request/grant and crossbar-select bundle between the router buffers
// (master) and the switch controller (slave).
interface hermes_switch_ctrl_if #(
   parameter int NPORT     = 5,
   parameter int FLIT_SIZE = 32,
   parameter int PORT_W    = 3
);
   logic [NPORT-1:0]                req;
   logic [NPORT-1:0]                sending;
   logic [NPORT-1:0][FLIT_SIZE-1:0] data;
   logic [NPORT-1:0]                ack;
   logic [NPORT-1:0]                free;
   logic [NPORT-1:0][PORT_W-1:0]    outport;
   logic [NPORT-1:0][PORT_W-1:0]    inport;

   modport master (
      output req, sending, data,
      input  ack, free, outport, inport
   );

   modport slave (
      input  req, sending, data,
      output ack, free, outport, inport
   );
endinterface

// File: rtl/hermes_switch_ctrl_arb.sv
// Round-robin arbiter: lowest requesting index after the last winner wins;
// the pointer only moves when update is asserted with a valid grant.
module hermes_rr_arbiter #(
   parameter  int N = 5,
   localparam int W = (N > 1) ? $clog2(N) : 1
)(
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [N-1:0] req,
   input  logic         update,
   output logic [W-1:0] grant,
   output logic         valid
);

   logic [W-1:0] ptr_q, ptr_d;

   // Scanning from the farthest offset down leaves the nearest requester in grant.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      for (int k = N; k >= 1; k--) begin
         if (req[W'((int'(ptr_q) + k) % N)]) begin
            grant = W'((int'(ptr_q) + k) % N);
            valid = 1'b1;
         end
      end
      ptr_d = (update && valid) ? grant : ptr_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= W'(N - 1);
      else         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/hermes_switch_ctrl.sv
// Hermes routing and switch-allocation controller for 4 cardinal plus
// NLOCAL local ports.
module hermes_switch_ctrl
   import hermes_switch_ctrl_pkg::*;
#(
   parameter  int                        FLIT_SIZE = 32,
   parameter  int                        X_BITS    = 8,
   parameter  int                        Y_BITS    = 8,
   parameter  int                        NLOCAL    = 1,
   parameter  logic [X_BITS+Y_BITS-1:0]  ADDRESS   = '0,
   parameter  hermes_routing_t           ROUTING   = HERMES_XY,
   localparam int NPORT  = HERMES_NCARDINAL + NLOCAL,
   localparam int PORT_W = $clog2(NPORT),
   localparam int LSEL_W = (NLOCAL > 1) ? $clog2(NLOCAL) : 1
)(
   input  logic                clk_i,
   input  logic                rst_ni,
   hermes_switch_ctrl_if.slave bus
);
   // state   | meaning
   // S_IDLE  | no allocation in progress, waiting for any request
   // S_ARBIT | round-robin pick of one requester into sel
   // S_ROUTE | route decision for the selected head flit into dest
   // S_GRANT | claim dest if free, otherwise retry arbitration
   // S_ACK   | one-cycle ack pulse to the selected input

   if (FLIT_SIZE < X_BITS + Y_BITS + LSEL_W + PORT_W + 1) begin : g_chk_flit
      $error("hermes_switch_ctrl: FLIT_SIZE too small for header fields");
   end
   if (NLOCAL < 1 || NLOCAL > 4) begin : g_chk_nlocal
      $error("hermes_switch_ctrl: NLOCAL must be 1..4");
   end

   hermes_state_t                state_q, state_d;
   logic [PORT_W-1:0]            sel_q, sel_d;
   logic [PORT_W-1:0]            dest_q, dest_d;
   logic [NPORT-1:0]             ack_q, ack_d;
   logic [NPORT-1:0]             free_q, free_d;
   logic [NPORT-1:0][PORT_W-1:0] outport_q, outport_d;
   logic [NPORT-1:0][PORT_W-1:0] inport_q, inport_d;
   logic [NPORT-1:0]             sending_q, sending_d;
   logic [NPORT-1:0]             rel;
   logic [PORT_W-1:0]            arb_grant;
   logic                         arb_valid;

   hermes_rr_arbiter #(.N(NPORT)) u_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req    (bus.req),
      .update (state_q == S_ARBIT),
      .grant  (arb_grant),
      .valid  (arb_valid)
   );

   assign sending_d = bus.sending;
   assign rel       = sending_q & ~bus.sending;

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      dest_d    = dest_q;
      ack_d     = '0;
      free_d    = free_q;
      outport_d = outport_q;
      inport_d  = inport_q;
      for (int i = 0; i < NPORT; i++) begin
         if (rel[i]) free_d[outport_q[i]] = 1'b1;
      end
      case (state_q)
         S_IDLE: if (|bus.req) state_d = S_ARBIT;
         S_ARBIT: begin
            if (arb_valid) begin
               sel_d   = arb_grant;
               state_d = S_ROUTE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ROUTE: begin
            dest_d = PORT_W'(hermes_route(
               bus.data[sel_q][FLIT_SIZE-1],
               32'(bus.data[sel_q][FLIT_SIZE-2 -: PORT_W]),
               32'(bus.data[sel_q][X_BITS+Y_BITS-1:Y_BITS]),
               32'(bus.data[sel_q][Y_BITS-1:0]),
               32'(ADDRESS[X_BITS+Y_BITS-1:Y_BITS]),
               32'(ADDRESS[Y_BITS-1:0]),
               32'(bus.data[sel_q][X_BITS+Y_BITS +: LSEL_W]),
               32'(NLOCAL),
               ROUTING));
            state_d = S_GRANT;
         end
         // The claim is applied after the releases so it wins a same-port collision.
         S_GRANT: begin
            if (free_q[dest_q]) begin
               outport_d[sel_q] = dest_q;
               inport_d[dest_q] = sel_q;
               free_d[dest_q]   = 1'b0;
               ack_d[sel_q]     = 1'b1;
               state_d          = S_ACK;
            end else begin
               state_d = S_ARBIT;
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         sel_q     <= '0;
         dest_q    <= '0;
         ack_q     <= '0;
         free_q    <= '1;
         outport_q <= '0;
         inport_q  <= '0;
         sending_q <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         dest_q    <= dest_d;
         ack_q     <= ack_d;
         free_q    <= free_d;
         outport_q <= outport_d;
         inport_q  <= inport_d;
         sending_q <= sending_d;
      end
   end

   assign bus.ack     = ack_q;
   assign bus.free    = free_q;
   assign bus.outport = outport_q;
   assign bus.inport  = inport_q;

endmodule
